alu_muldiv_seq: RTL and testbench

//  Multi-cycle unsigned MUL/DIV sequencer; drives the 33-bit 74181 ALU (a, m, aluf, alumode, cin0).

---
 rtl/alu_muldiv_seq_pkg.sv | 59 +++++
 rtl/alu_muldiv_seq_if.sv | 32 +++
 rtl/alu_muldiv_seq_fsm.sv | 71 +++++++
 rtl/alu_muldiv_seq.sv | 129 ++++++++++++
 tb/tb_alu_muldiv_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants and helpers for the alu_muldiv_seq MUL/DIV sequencer.
// Covers the 74181 function codes, the operation and state encodings, and the
// ALU drive bundle with one constructor for each kind of step.
package alu_muldiv_seq_pkg;

   // 74181 S[3:0] codes. With M=0 they are arithmetic; PASSM is used with M=1.
   localparam logic [3:0] ALUF_ADD   = 4'b1001;  // F = A plus B plus cin
   localparam logic [3:0] ALUF_SUB   = 4'b0110;  // F = A minus B minus 1 plus cin
   localparam logic [3:0] ALUF_PASSM = 4'b1111;  // F = A (logic mode)

   localparam logic MODE_ARITH = 1'b0;
   localparam logic MODE_LOGIC = 1'b1;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      STEP = 2'd2,
      DONE = 2'd3
   } state_e;

   // Everything the sequencer drives into the ALU in one cycle.
   typedef struct packed {
      logic [31:0] m;     // 74181 A side
      logic [31:0] a;     // 74181 B side
      logic [3:0]  f;
      logic        mode;
      logic        cin;
   } alu_drv_t;

   // Quiet drive used in reset, IDLE and DONE.
   function automatic alu_drv_t drv_idle();
      return '{m: 32'd0, a: 32'd0, f: ALUF_PASSM, mode: MODE_LOGIC, cin: 1'b0};
   endfunction

   // Multiply step: shift the accumulator, and add the multiplicand only if the
   // multiplier bit is set. Otherwise the shifted accumulator passes through.
   function automatic alu_drv_t drv_mul(input logic [31:0] acc, input logic [31:0] mcand,
                                        input logic bit_set);
      if (bit_set)
         return '{m: acc << 1, a: mcand, f: ALUF_ADD, mode: MODE_ARITH, cin: 1'b0};
      return '{m: acc << 1, a: mcand, f: ALUF_PASSM, mode: MODE_LOGIC, cin: 1'b0};
   endfunction

   // Restoring-divide trial subtraction. cin=1 turns A-B-1 into A-B.
   function automatic alu_drv_t drv_div(input logic [31:0] rs, input logic [31:0] divisor);
      return '{m: rs, a: divisor, f: ALUF_SUB, mode: MODE_ARITH, cin: 1'b1};
   endfunction

   // Zero-divisor probe: 0 - d - 1 is all ones exactly when d == 0, so aeqm flags it.
   function automatic alu_drv_t drv_zchk(input logic [31:0] divisor);
      return '{m: 32'd0, a: divisor, f: ALUF_SUB, mode: MODE_ARITH, cin: 1'b0};
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Bundle for the sequencer: the request/response side toward microcode and the
// drive/result side toward the 33-bit 74181 ALU.
// slave  = the sequencer.
// master = whoever drives requests and returns the ALU result.
interface alu_muldiv_seq_if #(parameter int DW = 16);
   logic          start;
   logic          op;
   logic [31:0]   opa;
   logic [DW-1:0] opb;
   logic          busy;
   logic          done;
   logic [31:0]   result;
   logic [31:0]   rem;
   logic          err;
   logic [31:0]   alu_m;
   logic [31:0]   alu_a;
   logic [3:0]    aluf;
   logic          alumode;
   logic          cin0;
   logic [32:0]   alu;
   logic          aeqm;

   modport slave (
      input  start, op, opa, opb, alu, aeqm,
      output busy, done, result, rem, err, alu_m, alu_a, aluf, alumode, cin0
   );

   modport master (
      output start, op, opa, opb, alu, aeqm,
      input  busy, done, result, rem, err, alu_m, alu_a, aluf, alumode, cin0
   );
endinterface

// File: rtl/alu_muldiv_seq_fsm.sv
// Sequencer control: IDLE -> LOAD -> STEP x N -> DONE -> IDLE.
// A 6-bit counter runs down from N-1 during STEP; last_o marks the final step.
// busy_o and done_o are registered.
module alu_muldiv_seq_fsm
   import alu_muldiv_seq_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   start_i,
   input  op_e    op_i,
   input  logic   skip_i,
   output state_e state_o,
   output logic   busy_o,
   output logic   done_o,
   output logic   last_o
);

   localparam logic [5:0] MUL_LAST = 6'(DW - 1);
   localparam logic [5:0] DIV_LAST = 6'd31;

   state_e     state_q;
   logic [5:0] cnt_q;
   logic       busy_q;
   logic       done_q;

   // State, step counter and registered busy/done flags.
   // NOTE: non-blocking everywhere here so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               state_q <= LOAD;
               busy_q  <= 1'b1;
            end
            LOAD: if (skip_i) begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               state_q <= STEP;
               cnt_q   <= (op_i == OP_DIV) ? DIV_LAST : MUL_LAST;
            end
            STEP: if (cnt_q == 6'd0) begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               cnt_q <= cnt_q - 6'd1;
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign state_o = state_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign last_o  = (state_q == STEP) && (cnt_q == 6'd0);

endmodule

// File: rtl/alu_muldiv_seq.sv
// Unsigned multiply (left-shift add) and restoring divide, performed one step
// per cycle on an external 33-bit 74181 ALU.
// Optional feature macro: ALU_MULDIV_DIVZERO_EN enables the zero-divisor probe
// in LOAD, the early DONE and the err flag.
// The running accumulator/remainder lives in the registered alu_m drive.
// Each step's ALU result is folded straight into the next drive.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int DW = 16
) (
   input logic             clk,
   input logic             reset,
   alu_muldiv_seq_if.slave bus
);

   state_e      state;
   logic        last;
   logic        skip;
   op_e         op_q;
   logic [31:0] opnd_q;    // ALU B-side operand: multiplicand or divisor
   logic [31:0] bits_q;    // multiplier (MSB-aligned) or dividend, consumed MSB first
   logic [30:0] q_q;       // quotient bits gathered so far
   logic [31:0] result_q;
   logic [31:0] rem_q;
   alu_drv_t    drv_q;

   logic [31:0] acc_n;
   logic [31:0] base;
   logic [31:0] q_n;
   alu_drv_t    step_drv;

   alu_muldiv_seq_fsm #(.DW(DW)) u_fsm (
      .clk     (clk),
      .reset   (reset),
      .start_i (bus.start),
      .op_i    (op_q),
      .skip_i  (skip),
      .state_o (state),
      .busy_o  (bus.busy),
      .done_o  (bus.done),
      .last_o  (last)
   );

`ifdef ALU_MULDIV_DIVZERO_EN
   logic err_q;
   assign skip    = (op_q == OP_DIV) && bus.aeqm;
   assign bus.err = err_q;
`else
   assign skip    = 1'b0;
   assign bus.err = 1'b0;
`endif

   // Fold this cycle's ALU result and build the next step's drive.
   // NOTE: every output gets a value on all paths so no latch is inferred.
   always_comb begin
      acc_n = bus.alu[31:0];
      if (op_q == OP_DIV && bus.alu[32])
         acc_n = drv_q.m;                // negative trial: restore Rs
      q_n      = {q_q, ~bus.alu[32]};
      base     = (state == LOAD) ? 32'd0 : acc_n;
      step_drv = drv_idle();
      if (op_q == OP_MUL)
         step_drv = drv_mul(base, opnd_q, bits_q[31]);
      else
         step_drv = drv_div({base[30:0], bits_q[31]}, opnd_q);
   end

   // Operand capture, step datapath, result registers and the ALU drive register.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q     <= OP_MUL;
         opnd_q   <= 32'd0;
         bits_q   <= 32'd0;
         q_q      <= 31'd0;
         result_q <= 32'd0;
         rem_q    <= 32'd0;
         drv_q    <= drv_idle();
`ifdef ALU_MULDIV_DIVZERO_EN
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               op_q   <= op_e'(bus.op);
               opnd_q <= (bus.op == OP_DIV) ? 32'(bus.opb) : bus.opa;
               bits_q <= (bus.op == OP_DIV) ? bus.opa : (32'(bus.opb) << (32 - DW));
`ifdef ALU_MULDIV_DIVZERO_EN
               err_q  <= 1'b0;
               drv_q  <= (bus.op == OP_DIV) ? drv_zchk(32'(bus.opb)) : drv_idle();
`endif
            end
            LOAD: if (skip) begin
               result_q <= 32'hFFFF_FFFF;
               rem_q    <= bits_q;       // dividend, still unshifted
               drv_q    <= drv_idle();
`ifdef ALU_MULDIV_DIVZERO_EN
               err_q    <= 1'b1;
`endif
            end else begin
               drv_q  <= step_drv;
               bits_q <= bits_q << 1;
               q_q    <= 31'd0;
            end
            STEP: begin
               q_q <= q_n[30:0];
               if (last) begin
                  result_q <= (op_q == OP_MUL) ? acc_n : q_n;
                  rem_q    <= (op_q == OP_MUL) ? 32'd0 : acc_n;
                  drv_q    <= drv_idle();
               end else begin
                  drv_q  <= step_drv;
                  bits_q <= bits_q << 1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result  = result_q;
   assign bus.rem     = rem_q;
   assign bus.alu_m   = drv_q.m;
   assign bus.alu_a   = drv_q.a;
   assign bus.aluf    = drv_q.f;
   assign bus.alumode = drv_q.mode;
   assign bus.cin0    = drv_q.cin;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq.
// A behavioural 74181 subset closes the ALU loop.
// Expected products, quotients and timing come from plain arithmetic.
// Honours ALU_MULDIV_DIVZERO_EN when defined.
module tb_alu_muldiv_seq;

   localparam int   DW     = 16;
   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef struct {
      logic [31:0] result;
      logic [31:0] rem;
      logic        err;
      int          n;          // number of STEP cycles
      int          start_cyc;
      bit          chk_data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];

   alu_muldiv_seq_if #(.DW(DW)) bus ();

   alu_muldiv_seq #(.DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural 74181 for the three functions used, on 33-bit sign-extended operands.
   logic [32:0] em, ea, alu_f;
   always_comb begin
      em    = {bus.alu_m[31], bus.alu_m};
      ea    = {bus.alu_a[31], bus.alu_a};
      alu_f = 33'd0;
      if (bus.alumode) begin
         if (bus.aluf == 4'b1111) alu_f = em;
      end else begin
         case (bus.aluf)
            4'b1001: alu_f = em + ea + 33'(bus.cin0);
            4'b0110: alu_f = em - ea - 33'd1 + 33'(bus.cin0);
            default: alu_f = 33'd0;
         endcase
      end
   end
   assign bus.alu  = alu_f;
   assign bus.aeqm = &alu_f;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"},    64'(bus.busy),    64'd0);
      check({tag, "_done"},    64'(bus.done),    64'd0);
      check({tag, "_err"},     64'(bus.err),     64'd0);
      check({tag, "_result"},  64'(bus.result),  64'd0);
      check({tag, "_rem"},     64'(bus.rem),     64'd0);
      check({tag, "_alu_m"},   64'(bus.alu_m),   64'd0);
      check({tag, "_alu_a"},   64'(bus.alu_a),   64'd0);
      check({tag, "_aluf"},    64'(bus.aluf),    64'hF);
      check({tag, "_alumode"}, 64'(bus.alumode), 64'd1);
      check({tag, "_cin0"},    64'(bus.cin0),    64'd0);
   endtask

   // Reference model: what a request must return, from plain arithmetic.
   function automatic exp_t model(input logic op, input logic [31:0] a, input logic [15:0] b);
      exp_t        e;
      logic [63:0] p;
      e.chk_data = 1'b1;
      e.err      = 1'b0;
      e.rem      = 32'd0;
      e.start_cyc = 0;
      if (op == OP_MUL) begin
         p        = 64'(a) * 64'(b);
         e.result = p[31:0];
         e.n      = DW;
      end else if (b == 16'd0) begin
`ifdef ALU_MULDIV_DIVZERO_EN
         e.result = 32'hFFFF_FFFF;
         e.rem    = a;
         e.err    = 1'b1;
         e.n      = 0;
`else
         e.result   = 32'd0;
         e.chk_data = 1'b0;
         e.n        = 32;
`endif
      end else begin
         e.result = a / 32'(b);
         e.rem    = a % 32'(b);
         e.n      = 32;
      end
      return e;
   endfunction

   // Monitor: cycle-accurate busy/done window and result comparison on done.
   always @(negedge clk) begin
      int   idx;
      logic eb, ed;
      exp_t e;
      if (mon_en && !reset) begin
         eb = 1'b0;
         ed = 1'b0;
         if (exp_q.size() > 0) begin
            idx = cyc - exp_q[0].start_cyc;
            eb  = (idx >= 1) && (idx <= exp_q[0].n + 1);
            ed  = (idx == exp_q[0].n + 2);
         end
         check("busy", 64'(bus.busy), 64'(eb));
         check("done", 64'(bus.done), 64'(ed));
         if (bus.done && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("err", 64'(bus.err), 64'(e.err));
            if (e.chk_data) begin
               check("result", 64'(bus.result), 64'(e.result));
               check("rem",    64'(bus.rem),    64'(e.rem));
            end
         end
      end
   end

   // Issue one request, scramble operands afterwards, optionally poke start
   // mid-operation or in DONE, and wait (bounded) for done.
   task automatic issue(input logic op, input logic [31:0] a, input logic [15:0] b,
                        input bit mid_start, input bit done_start);
      exp_t e;
      bit   got;
      e = model(op, a, b);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op    = op;
      bus.opa   = a;
      bus.opb   = b;
      e.start_cyc = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.opa   = $urandom;
      bus.opb   = 16'($urandom);
      if (mid_start) begin
         repeat (5) @(posedge clk);
         #1;
         bus.start = 1'b1;
         bus.op    = ~op;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (bus.done) got = 1'b1;
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL done_timeout: got no done expected done within 200 cycles");
         exp_q.delete();
      end else if (done_start) begin
         bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
   endtask

   initial begin
      logic        o;
      logic [31:0] a;
      logic [15:0] b;
      int          sel;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = OP_MUL;
      bus.opa   = 32'd0;
      bus.opb   = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("rst");
      @(posedge clk); #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      issue(OP_MUL, 32'h1234, 16'h5678, 1'b0, 1'b0);
      issue(OP_MUL, 32'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      issue(OP_DIV, 32'd100000, 16'd7, 1'b0, 1'b0);
      issue(OP_DIV, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b0);
      issue(OP_DIV, 32'h1234_5678, 16'd0, 1'b0, 1'b0);
      issue(OP_DIV, 32'd5, 16'd9, 1'b0, 1'b0);
      issue(OP_DIV, 32'hDEAD_BEEF, 16'd1, 1'b0, 1'b0);
      issue(OP_MUL, 32'hABCD, 16'd0, 1'b0, 1'b0);
      issue(OP_MUL, 32'hFFFF, 16'h8000, 1'b0, 1'b1);

      for (int k = 0; k < 40; k++) begin
         o   = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 7);
         if (o == OP_MUL) begin
            a = $urandom & 32'h0000_FFFF;
            b = 16'($urandom);
         end else begin
            a = $urandom;
            b = (sel == 0) ? 16'($urandom_range(1, 3)) :
                (sel == 1) ? 16'd0 : 16'($urandom);
         end
         issue(o, a, b, 1'b0, sel == 2);
      end

      // Reset during STEP 10 of a divide: everything returns to the reset state.
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op    = OP_DIV;
      bus.opa   = 32'h8765_4321;
      bus.opb   = 16'd13;
      begin
         exp_t e;
         e = model(OP_DIV, 32'h8765_4321, 16'd13);
         e.start_cyc = cyc;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_state("midrst");

      issue(OP_MUL, 32'd3, 16'd5, 1'b0, 1'b0);

      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
